// File: rtl/mac_execute_unit.sv
// rtl/mac_execute_unit.sv - EX-stage multi-cycle shift-add multiply / multiply-accumulate unit
// Consumes forwarded operands, holds a private accumulator, stalls the pipeline via busy_o.
module mac_execute_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] acc_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MAC   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_RDACC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  prod_q, prod_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mac_q, mac_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_ok;

  // A flush in the same cycle as a request always drops the request.
  assign req_ok = start_i && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_ok && (op_i == OP_MUL || op_i == OP_MAC)) begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_ITER) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    mac_d  = mac_q;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          case (op_i)
            OP_MUL, OP_MAC: begin
              a_d    = src_a_i;
              b_d    = src_b_i;
              prod_d = '0;
              cnt_d  = '0;
              mac_d  = (op_i == OP_MAC);
            end
            OP_CLR: begin
              acc_d  = '0;
              res_d  = '0;
              done_d = 1'b1;
            end
            default: begin
              res_d  = acc_q;
              done_d = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        if (!flush_i) begin
          if (b_q[0]) begin
            prod_d = prod_q + a_q;
          end
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        // Flush beats completion: no result, no accumulator update.
        if (!flush_i) begin
          if (mac_q) begin
            acc_d = acc_q + prod_q;
            res_d = acc_q + prod_q;
          end else begin
            res_d = prod_q;
          end
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      mac_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      mac_q  <= mac_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;
  assign acc_o    = acc_q;

endmodule

// File: tb/tb_mac_execute_unit.sv
// tb/tb_mac_execute_unit.sv - scoreboard bench for mac_execute_unit
// Expected {result, acc} pairs are queued at issue and popped on each done pulse.
module tb_mac_execute_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] src_a_i;
  logic [W-1:0] src_b_i;
  logic         flush_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic [W-1:0] acc_o;

  mac_execute_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .acc_o    (acc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_cnt = 0;
  logic [W-1:0] model_acc = '0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          check("result", result_o, e[2*W-1:W]);
          check("acc", acc_o, e[W-1:0]);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track);
    logic [W-1:0] r;
    @(posedge clk); #2;
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    @(posedge clk); #2;
    start_i = 1'b0;
    if (track) begin
      case (op)
        2'b00: r = a * b;
        2'b01: begin model_acc = model_acc + a * b; r = model_acc; end
        2'b10: begin model_acc = '0; r = '0; end
        default: r = model_acc;
      endcase
      exp_q.push_back({r, model_acc});
    end
  endtask

  task automatic wait_done();
    int s;
    s = done_seen;
    for (int i = 0; i < 60 && done_seen == s; i++) begin
      @(negedge clk); #1;
    end
    if (done_seen == s) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int d0;
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; src_a_i = '0; src_b_i = '0; flush_i = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_acc", acc_o, 32'd0);

    // MUL 3x5 with busy length
    busy_cnt = 0;
    issue(2'b00, 32'd3, 32'd5, 1'b1);
    wait_done();
    check("mul_busy_len", busy_cnt, 32'd33);

    // MAC chain and RDACC
    issue(2'b10, 32'd0, 32'd0, 1'b1);
    wait_done();
    issue(2'b01, 32'd2, 32'd7, 1'b1);
    wait_done();
    issue(2'b01, 32'd4, 32'd4, 1'b1);
    wait_done();
    busy_cnt = 0;
    issue(2'b11, 32'd0, 32'd0, 1'b1);
    wait_done();
    check("rdacc_no_busy", busy_cnt, 32'd0);

    // wrap cases
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    issue(2'b10, 32'd0, 32'd0, 1'b1);
    wait_done();
    issue(2'b01, 32'hFFFF_FFF0, 32'd1, 1'b1);
    wait_done();
    issue(2'b01, 32'd4, 32'd5, 1'b1);
    wait_done();
    check("wrap_acc", acc_o, 32'd4);

    // start and operand changes while busy are ignored
    busy_cnt = 0;
    issue(2'b00, 32'd6, 32'd9, 1'b1);
    idle(3);
    start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd100; src_b_i = 32'd77;
    idle(2);
    start_i = 1'b0; src_a_i = 32'd13;
    wait_done();
    check("busy_ignore_len", busy_cnt, 32'd33);

    // flush mid-MAC with acc = 100
    issue(2'b10, 32'd0, 32'd0, 1'b1);
    wait_done();
    issue(2'b01, 32'd10, 32'd10, 1'b1);
    wait_done();
    d0 = done_seen;
    issue(2'b01, 32'd3, 32'd3, 1'b0);
    idle(8);
    flush_i = 1'b1;
    idle(1);
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    idle(40);
    check("flush_no_done", done_seen - d0, 32'd0);
    check("flush_acc", acc_o, 32'd100);

    // flush together with start in IDLE
    d0 = done_seen;
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; src_a_i = 32'd2; src_b_i = 32'd2;
    idle(1);
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'd0, busy_o}, 32'd0);
    idle(40);
    check("flush_start_no_done", done_seen - d0, 32'd0);

    // reset mid-MAC
    issue(2'b01, 32'd5, 32'd5, 1'b0);
    idle(18);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_acc", acc_o, 32'd0);
    model_acc = '0;
    idle(2);
    rst = 1'b0;
    issue(2'b00, 32'd8, 32'd8, 1'b1);
    wait_done();

    // random MAC/MUL mix
    for (int i = 0; i < 4; i++) begin
      issue(2'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
      wait_done();
    end
    issue(2'b11, 32'd0, 32'd0, 1'b1);
    wait_done();

    idle(2);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
